// File: rtl/ws_pkg.sv
// Shared types and constants for the WS2812 frame scheduler.
package ws_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        LATCH = 2'd3
    } ws_state_e;

    localparam int NUM_PIX = 16;

    typedef logic [23:0] ws_grb_t;

    localparam ws_grb_t ON_GRB_DEF  = 24'h00_20_00;
    localparam ws_grb_t OFF_GRB_DEF = 24'h00_00_00;

endpackage

// File: rtl/ws_frame_sched_if.sv
// Pixel stream between the frame scheduler (master) and the bit-serial driver (slave).
interface ws_frame_sched_if;
    import ws_pkg::*;

    ws_grb_t pix_data;
    logic    pix_valid;
    logic    pix_ready;
    logic    drv_idle;

    modport master (output pix_data, output pix_valid, input pix_ready, input drv_idle);
    modport slave  (input pix_data, input pix_valid, output pix_ready, output drv_idle);

endinterface

// File: rtl/ws_gap_timer.sv
// Latch-gap timer: cleared by load, counts while enabled, flags the last gap cycle.
module ws_gap_timer #(
    parameter int LATCH_CYCLES = 600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = (LATCH_CYCLES > 2) ? $clog2(LATCH_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == CW'(LATCH_CYCLES - 1));

    // Next count: restart on load, advance while enabled, fall back to 0 on expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = expire_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ws_frame_sched.sv
// Frame scheduler: snapshots four BCD digits on update and streams 16 GRB pixels,
// then waits for the driver to drain and holds the latch gap before the next frame.
//
//  state | meaning
//  IDLE  | no frame; start on update or pending
//  SEND  | presenting pixel idx_q, advance on each transfer
//  DRAIN | all 16 words accepted, waiting for drv_idle
//  LATCH | holding the line low for LATCH_CYCLES cycles
module ws_frame_sched
    import ws_pkg::*;
#(
    parameter ws_grb_t ON_GRB       = ON_GRB_DEF,
    parameter ws_grb_t OFF_GRB      = OFF_GRB_DEF,
    parameter int      LATCH_CYCLES = 600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              update,
    input  logic [3:0]        h1,
    input  logic [3:0]        h0,
    input  logic [3:0]        m1,
    input  logic [3:0]        m0,
    output logic              busy,
    output logic              frame_done,
    ws_frame_sched_if.master  pix
);
    ws_state_e   state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] snap_q, snap_d;
    logic        pending_q, pending_d;
    logic        frame_done_q, frame_done_d;
    logic        gap_load;
    logic        gap_expire;

    ws_gap_timer #(.LATCH_CYCLES(LATCH_CYCLES)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (gap_load),
        .en_i     (state_q == LATCH),
        .expire_o (gap_expire)
    );

    // Next-state, snapshot, index and pending-flag logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        gap_load     = 1'b0;

        // Strobes while a frame is in flight collapse into one deferred start.
        if (update && (state_q != IDLE)) pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (update || pending_q) begin
                    state_d   = SEND;
                    // Column c occupies bits [4c+3:4c], so pixel i maps to snap[i].
                    snap_d    = {m0, m1, h0, h1};
                    idx_d     = 4'd0;
                    pending_d = 1'b0;
                end
            end
            SEND: begin
                if (pix.pix_ready) begin
                    if (idx_q == 4'(NUM_PIX - 1)) begin
                        state_d = DRAIN;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (pix.drv_idle) begin
                    state_d  = LATCH;
                    gap_load = 1'b1;
                end
            end
            LATCH: begin
                if (gap_expire) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            snap_q       <= 16'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix.pix_valid = (state_q == SEND);
    assign pix.pix_data  = ((state_q == SEND) && snap_q[idx_q]) ? ON_GRB : OFF_GRB;
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_ws_frame_sched.sv
// Directed bench for ws_frame_sched.
module tb_ws_frame_sched;
    import ws_pkg::*;

    localparam int LC = 600;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       update;
    logic [3:0] h1, h0, m1, m0;
    logic       busy, frame_done;

    int vecs = 0;
    int errs = 0;

    ws_frame_sched_if pif ();

    ws_frame_sched #(.LATCH_CYCLES(LC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .update     (update),
        .h1         (h1),
        .h0         (h0),
        .m1         (m1),
        .m0         (m0),
        .busy       (busy),
        .frame_done (frame_done),
        .pix        (pif)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one edge; samples are taken 2 ns after it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic ws_grb_t exp_px(input logic [3:0] dh1, dh0, dm1, dm0, input int i);
        logic [3:0] d;
        case (i / 4)
            0:       d = dh1;
            1:       d = dh0;
            2:       d = dm1;
            default: d = dm0;
        endcase
        return d[i % 4] ? ON_GRB_DEF : OFF_GRB_DEF;
    endfunction

    // Bounded wait for frame_done; cycles = -1 on timeout.
    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (frame_done === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen = 0;
        rst_n = 1'b0; update = 1'b0;
        h1 = 0; h0 = 0; m1 = 0; m0 = 0;
        pif.pix_ready = 1'b1; pif.drv_idle = 1'b1;
        repeat (3) step();
        vecs++; if (pif.pix_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", pif.pix_valid); end
        vecs++; if (pif.pix_data !== OFF_GRB_DEF) begin errs++; $display("FAIL reset_data: got %h expected %h", pif.pix_data, OFF_GRB_DEF); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        rst_n = 1'b1;
        repeat (50) begin
            step();
            if (pif.pix_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        vecs++; if (seen != 0) begin errs++; $display("FAIL idle_quiet: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_single_frame();
        bit      exp_on [16] = '{1,0,0,0, 0,1,0,0, 1,1,0,0, 0,0,1,0};
        ws_grb_t got [16];
        ws_grb_t want;
        int      n = 0, cyc = 0, done_at = -1;
        bit      bubble = 0, late_valid = 0;
        h1 = 1; h0 = 2; m1 = 3; m0 = 4;
        pif.pix_ready = 1'b1; pif.drv_idle = 1'b1;
        update = 1'b1; step(); update = 1'b0;
        vecs++; if (pif.pix_valid !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL start_latency: got valid=%b busy=%b expected 1/1", pif.pix_valid, busy); end
        // cyc = number of edges since the strobe edge.
        while (done_at < 0 && cyc < 2000) begin
            if (pif.pix_valid === 1'b1 && pif.pix_ready === 1'b1) begin
                if (n < 16) got[n] = pif.pix_data;
                n++;
            end
            if (cyc < 16 && pif.pix_valid !== 1'b1) bubble = 1;
            if (cyc == 16 && pif.pix_valid !== 1'b0) late_valid = 1;
            step(); cyc++;
            if (frame_done === 1'b1) done_at = cyc;
        end
        vecs++; if (bubble) begin errs++; $display("FAIL zero_bubble: got gap expected 16 valid cycles"); end
        vecs++; if (late_valid) begin errs++; $display("FAIL valid_fall: got 1 expected 0 after 16th transfer"); end
        vecs++; if (n != 16) begin errs++; $display("FAIL single_count: got %0d expected 16", n); end
        for (int i = 0; i < 16; i++) begin
            want = exp_on[i] ? ON_GRB_DEF : OFF_GRB_DEF;
            vecs++; if (got[i] !== want) begin errs++; $display("FAIL single_px%0d: got %h expected %h", i, got[i], want); end
        end
        // Pulse seen in cycle 16+1+LC+1 after the strobe, i.e. after edge 16+1+LC.
        vecs++; if (done_at != 16 + 1 + LC) begin errs++; $display("FAIL frame_period: got %0d expected %0d", done_at, 16 + 1 + LC); end
        step();
        vecs++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL done_pulse: got done=%b busy=%b expected 0/0", frame_done, busy); end
    endtask

    task automatic test_backpressure();
        ws_grb_t got [16];
        ws_grb_t prev_data = '0;
        ws_grb_t want;
        bit      prev_stall = 0;
        int      n = 0, cyc = 0, c;
        h1 = 2; h0 = 3; m1 = 5; m0 = 9;
        pif.pix_ready = 1'b0; pif.drv_idle = 1'b1;
        update = 1'b1; step(); update = 1'b0;
        while (pif.pix_valid === 1'b1 && cyc < 400) begin
            if (prev_stall) begin
                vecs++; if (pif.pix_data !== prev_data) begin errs++; $display("FAIL stall_hold: got %h expected %h", pif.pix_data, prev_data); end
            end
            pif.pix_ready = 1'($urandom_range(0, 1));
            if (n == 5) begin h1 = 4'hf; h0 = 4'h0; m1 = 4'hf; m0 = 4'h0; end
            if (pif.pix_ready === 1'b1) begin
                if (n < 16) got[n] = pif.pix_data;
                n++;
            end
            prev_stall = (pif.pix_ready !== 1'b1);
            prev_data  = pif.pix_data;
            step(); cyc++;
        end
        vecs++; if (n != 16) begin errs++; $display("FAIL bp_count: got %0d expected 16", n); end
        for (int i = 0; i < 16; i++) begin
            want = exp_px(4'd2, 4'd3, 4'd5, 4'd9, i);
            vecs++; if (got[i] !== want) begin errs++; $display("FAIL bp_px%0d: got %h expected %h", i, got[i], want); end
        end
        pif.pix_ready = 1'b1;
        wait_done(2000, c);
        vecs++; if (c < 0) begin errs++; $display("FAIL bp_done: got timeout expected frame_done"); end
    endtask

    task automatic test_pending();
        ws_grb_t got [16];
        ws_grb_t want;
        int      c, bad = 0, extra = 0;
        h1 = 1; h0 = 1; m1 = 1; m0 = 1;
        pif.pix_ready = 1'b1; pif.drv_idle = 1'b1;
        update = 1'b1; step(); update = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            update = 1'b0;
            if (k == 3) begin h1 = 4; h0 = 4; m1 = 4; m0 = 4; update = 1'b1; end
            if (k == 6) begin h1 = 7; h0 = 7; m1 = 7; m0 = 7; update = 1'b1; end
            if (k == 9) begin h1 = 0; h0 = 0; m1 = 5; m0 = 9; update = 1'b1; end
            step();
        end
        update = 1'b0;
        wait_done(2000, c);
        vecs++; if (c < 0) begin errs++; $display("FAIL pend_first_done: got timeout expected frame_done"); end
        step();
        vecs++; if (pif.pix_valid !== 1'b1) begin errs++; $display("FAIL pend_restart: got valid=%b expected 1", pif.pix_valid); end
        for (int j = 0; j < 16; j++) begin
            if (pif.pix_valid !== 1'b1) bad++;
            got[j] = pif.pix_data;
            step();
        end
        vecs++; if (bad != 0) begin errs++; $display("FAIL pend_valid: got %0d invalid cycles expected 0", bad); end
        for (int i = 0; i < 16; i++) begin
            want = exp_px(4'd0, 4'd0, 4'd5, 4'd9, i);
            vecs++; if (got[i] !== want) begin errs++; $display("FAIL pend_px%0d: got %h expected %h", i, got[i], want); end
        end
        wait_done(2000, c);
        vecs++; if (c < 0) begin errs++; $display("FAIL pend_second_done: got timeout expected frame_done"); end
        repeat (50) begin
            step();
            if (pif.pix_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        vecs++; if (extra != 0) begin errs++; $display("FAIL pend_collapse: got %0d busy cycles expected 0", extra); end
    endtask

    task automatic test_drain();
        int bad = 0, k = 0;
        h1 = 3; h0 = 1; m1 = 4; m0 = 1;
        pif.pix_ready = 1'b1; pif.drv_idle = 1'b0;
        update = 1'b1; step(); update = 1'b0;
        repeat (16) begin
            if (pif.pix_valid !== 1'b1) bad++;
            step();
        end
        vecs++; if (bad != 0) begin errs++; $display("FAIL drain_send: got %0d invalid cycles expected 0", bad); end
        bad = 0;
        repeat (40) begin
            pif.pix_ready = 1'($urandom_range(0, 1));
            if (pif.pix_valid !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) bad++;
            step();
        end
        vecs++; if (bad != 0) begin errs++; $display("FAIL drain_hold: got %0d bad cycles expected 0", bad); end
        pif.pix_ready = 1'b1;
        pif.drv_idle  = 1'b1;
        step();
        while (frame_done !== 1'b1 && k < 2000) begin
            step(); k++;
        end
        vecs++; if (k != LC) begin errs++; $display("FAIL latch_len: got %0d expected %0d", k, LC); end
    endtask

    task automatic test_reset_mid();
        ws_grb_t got [16];
        ws_grb_t want;
        int      c;
        h1 = 1; h0 = 2; m1 = 3; m0 = 4;
        pif.pix_ready = 1'b1; pif.drv_idle = 1'b1;
        update = 1'b1; step(); update = 1'b0;
        repeat (7) step();
        vecs++; if (pif.pix_valid !== 1'b1) begin errs++; $display("FAIL mid_valid: got %b expected 1", pif.pix_valid); end
        rst_n = 1'b0; step();
        vecs++; if (pif.pix_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL mid_reset: got valid=%b busy=%b expected 0/0", pif.pix_valid, busy); end
        vecs++; if (pif.pix_data !== OFF_GRB_DEF) begin errs++; $display("FAIL mid_reset_data: got %h expected %h", pif.pix_data, OFF_GRB_DEF); end
        rst_n = 1'b1; step();
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_no_restart: got busy=%b expected 0", busy); end
        h1 = 1; h0 = 0; m1 = 0; m0 = 9;
        update = 1'b1; step(); update = 1'b0;
        for (int j = 0; j < 16; j++) begin
            got[j] = pif.pix_data;
            step();
        end
        for (int i = 0; i < 16; i++) begin
            want = exp_px(4'd1, 4'd0, 4'd0, 4'd9, i);
            vecs++; if (got[i] !== want) begin errs++; $display("FAIL restart_px%0d: got %h expected %h", i, got[i], want); end
        end
        wait_done(2000, c);
        vecs++; if (c < 0) begin errs++; $display("FAIL restart_done: got timeout expected frame_done"); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_pending();
        test_drain();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
